kpad_digit_store: RTL and testbench



---
 rtl/kpad_digit_store.sv | 176 +++++++++++++++++
 tb/tb_kpad_digit_store.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kpad_digit_store.sv
// kpad_digit_store
// Receives accepted keys from the keypad scanner and decodes each one-hot
// row/column pair to a hex key code. It keeps the two most recent codes and
// time-multiplexes them onto a shared active-low seven-segment bus. The right
// digit (an[0]) shows the newest key and the left digit (an[1]) shows the
// previous one.

module kpad_digit_store #(
  parameter int MUX_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row_pressed,
  input  logic [3:0] col,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic [1:0] valid,
  output logic       key_err,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [MUX_BITS-1:0] CNT_ONE = MUX_BITS'(1);
  localparam logic [6:0]          SEG_BLANK = 7'h7F;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when exactly one bit of the nibble is set.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Bit position of a one-hot nibble. Callers only pass one-hot values.
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad layout: row index in the upper two bits, column index in the lower.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Active-low segment patterns, bit 0 = segment a and bit 6 = segment g.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    p = SEG_BLANK;
    case (d)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      4'hF: p = 7'h0E;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Key qualification and decode
  // ---------------------------------------------------------------------------

  logic       key_ok;
  logic [3:0] key_decoded;
  logic       capture;
  logic       reject;

  // Qualify the strobe and decode the pressed key.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    key_ok      = is_onehot(row_pressed) && is_onehot(col);
    key_decoded = key_code(onehot_index(row_pressed), onehot_index(col));
    capture     = enable && key_ok;
    reject      = enable && !key_ok;
  end

  // ---------------------------------------------------------------------------
  // Digit history
  // ---------------------------------------------------------------------------

  // Shift a newly captured key into the two-digit history. An invalid strobe
  // only raises the one-cycle error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      valid     <= 2'b00;
      key_err   <= 1'b0;
    end else begin
      key_err <= reject;
      if (capture) begin
        digit_old <= digit_new;
        digit_new <= key_decoded;
        valid     <= {valid[0], 1'b1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh
  // ---------------------------------------------------------------------------

  logic [MUX_BITS-1:0] refresh_cnt;
  logic                sel;

  // Free-running refresh counter. The digit select flips on the wrap cycle,
  // and key activity never disturbs it.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      sel         <= 1'b0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_ONE;
      if (&refresh_cnt) begin
        sel <= ~sel;
      end
    end
  end

  logic [3:0] shown_digit;
  logic       shown_valid;

  // Drive the anodes and the segment pattern of the selected digit. An empty
  // history slot stays blank.
  always_comb begin
    shown_digit = sel ? digit_old : digit_new;
    shown_valid = sel ? valid[1] : valid[0];
    an          = sel ? 2'b01 : 2'b10;
    seg         = shown_valid ? seg_pattern(shown_digit) : SEG_BLANK;
  end

endmodule

// File: tb/tb_kpad_digit_store.sv
// Directed testbench for kpad_digit_store with a short refresh period
// (MUX_BITS=3). A small reference model tracks the expected history and
// refresh phase. Expected key codes and segment patterns are constants
// taken from the keypad and display tables.

module tb_kpad_digit_store;

  localparam int MUX_BITS = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] row_pressed;
  logic [3:0] col;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic [1:0] valid;
  logic       key_err;
  logic [6:0] seg;
  logic [1:0] an;

  kpad_digit_store #(.MUX_BITS(MUX_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .row_pressed (row_pressed),
    .col         (col),
    .digit_new   (digit_new),
    .digit_old   (digit_old),
    .valid       (valid),
    .key_err     (key_err),
    .seg         (seg),
    .an          (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference refresh phase: number of edges since the last reset edge.
  int unsigned edges_since_reset = 0;
  always @(posedge clk) begin
    if (reset) edges_since_reset <= 0;
    else       edges_since_reset <= edges_since_reset + 1;
  end

  function automatic logic model_sel();
    return ((edges_since_reset >> MUX_BITS) & 1) != 0;
  endfunction

  // Reference history.
  logic [3:0] exp_new, exp_old;
  logic [1:0] exp_valid;
  logic       exp_err;
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic       bad;
    logic [3:0] code;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    logic s;
    s = model_sel();
    if (s) return exp_valid[1] ? seg_tab[exp_old] : 7'h7F;
    else   return exp_valid[0] ? seg_tab[exp_new] : 7'h7F;
  endfunction

  task automatic check_all(input string name);
    check({name, ".digit_new"}, {4'h0, digit_new}, {4'h0, exp_new});
    check({name, ".digit_old"}, {4'h0, digit_old}, {4'h0, exp_old});
    check({name, ".valid"},     {6'h0, valid},     {6'h0, exp_valid});
    check({name, ".key_err"},   {7'h0, key_err},   {7'h0, exp_err});
    check({name, ".an"},        {6'h0, an},        model_sel() ? 8'h01 : 8'h02);
    check({name, ".seg"},       {1'b0, seg},       {1'b0, exp_seg()});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enable pulse; the model follows the hand-computed expectation.
  task automatic press(input logic [3:0] r, input logic [3:0] c,
                       input logic bad, input logic [3:0] code, input string name);
    row_pressed = r;
    col         = c;
    enable      = 1'b1;
    tick();
    enable      = 1'b0;
    row_pressed = 4'h0;
    col         = 4'h0;
    if (bad) begin
      exp_err = 1'b1;
    end else begin
      exp_err   = 1'b0;
      exp_old   = exp_new;
      exp_new   = code;
      exp_valid = {exp_valid[0], 1'b1};
    end
    check_all(name);
    exp_err = 1'b0;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(name);
    end
  endtask

  task automatic idle_until_sel(input logic s);
    while (model_sel() != s) tick();
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Full sweep in keypad order, followed by malformed strobes.
    vecs[0]  = '{4'b0001, 4'b0001, 1'b0, 4'h1};
    vecs[1]  = '{4'b0001, 4'b0010, 1'b0, 4'h2};
    vecs[2]  = '{4'b0001, 4'b0100, 1'b0, 4'h3};
    vecs[3]  = '{4'b0001, 4'b1000, 1'b0, 4'hA};
    vecs[4]  = '{4'b0010, 4'b0001, 1'b0, 4'h4};
    vecs[5]  = '{4'b0010, 4'b0010, 1'b0, 4'h5};
    vecs[6]  = '{4'b0010, 4'b0100, 1'b0, 4'h6};
    vecs[7]  = '{4'b0010, 4'b1000, 1'b0, 4'hB};
    vecs[8]  = '{4'b0100, 4'b0001, 1'b0, 4'h7};
    vecs[9]  = '{4'b0100, 4'b0010, 1'b0, 4'h8};
    vecs[10] = '{4'b0100, 4'b0100, 1'b0, 4'h9};
    vecs[11] = '{4'b0100, 4'b1000, 1'b0, 4'hC};
    vecs[12] = '{4'b1000, 4'b0001, 1'b0, 4'hE};
    vecs[13] = '{4'b1000, 4'b0010, 1'b0, 4'h0};
    vecs[14] = '{4'b1000, 4'b0100, 1'b0, 4'hF};
    vecs[15] = '{4'b1000, 4'b1000, 1'b0, 4'hD};
    vecs[16] = '{4'b0001, 4'b0110, 1'b1, 4'h0};
    vecs[17] = '{4'b0000, 4'b0001, 1'b1, 4'h0};
    vecs[18] = '{4'b0011, 4'b0100, 1'b1, 4'h0};
    vecs[19] = '{4'b0100, 4'b0000, 1'b1, 4'h0};

    exp_new = 4'h0; exp_old = 4'h0; exp_valid = 2'b00; exp_err = 1'b0;
    enable = 1'b0; row_pressed = 4'h0; col = 4'h0;

    // Reset, then idle through both refresh phases.
    reset = 1'b1;
    tick();
    tick();
    check_all("reset");
    reset = 1'b0;
    idle(20, "idle_blank");

    // First key: 2 on the right, left still blank.
    press(4'b0001, 4'b0010, 1'b0, 4'h2, "key2");
    idle_until_sel(1'b0);
    check("key2.right_seg", {1'b0, seg}, 8'h24);
    check("key2.right_an", {6'h0, an}, 8'h02);
    idle_until_sel(1'b1);
    check("key2.left_seg", {1'b0, seg}, 8'h7F);
    check("key2.left_an", {6'h0, an}, 8'h01);

    // Second key: D on the right, 2 moves left.
    press(4'b1000, 4'b1000, 1'b0, 4'hD, "keyD");
    idle_until_sel(1'b0);
    check("keyD.right_seg", {1'b0, seg}, 8'h21);
    idle_until_sel(1'b1);
    check("keyD.left_seg", {1'b0, seg}, 8'h24);

    // Malformed strobes: one-cycle error, history untouched.
    press(4'b0001, 4'b0110, 1'b1, 4'h0, "err_multicol");
    idle(1, "err_multicol_clear");
    press(4'b0000, 4'b0001, 1'b1, 4'h0, "err_norow");
    idle(1, "err_norow_clear");
    check("err.history", {digit_old, digit_new}, 8'h2D);

    // Table sweep: 16 keys plus malformed strobes, with idle gaps.
    for (int i = 0; i < 20; i++) begin
      press(vecs[i].row, vecs[i].col, vecs[i].bad, vecs[i].code, $sformatf("vec%0d", i));
      idle(5, $sformatf("vec%0d_idle", i));
    end

    // Back-to-back strobes are both captured in order.
    row_pressed = 4'b0010; col = 4'b0010; enable = 1'b1;
    tick();
    exp_old = exp_new; exp_new = 4'h5; exp_valid = {exp_valid[0], 1'b1};
    check_all("b2b_first");
    row_pressed = 4'b0100; col = 4'b0100;
    tick();
    enable = 1'b0; row_pressed = 4'h0; col = 4'h0;
    exp_old = 4'h5; exp_new = 4'h9;
    check_all("b2b_second");
    check("b2b.pair", {digit_old, digit_new}, 8'h59);

    // Capture on the same edge as a refresh select toggle.
    while (edges_since_reset % (1 << MUX_BITS) != (1 << MUX_BITS) - 1) tick();
    press(4'b0001, 4'b0100, 1'b0, 4'h3, "capture_on_wrap");
    idle(3, "after_wrap");

    // Reset wins over a simultaneous enable.
    idle(3, "pre_reset");
    reset = 1'b1; enable = 1'b1; row_pressed = 4'b0100; col = 4'b0001;
    tick();
    reset = 1'b0; enable = 1'b0; row_pressed = 4'h0; col = 4'h0;
    exp_new = 4'h0; exp_old = 4'h0; exp_valid = 2'b00; exp_err = 1'b0;
    check_all("reset_vs_enable");
    check("reset_vs_enable.seg", {1'b0, seg}, 8'h7F);
    check("reset_vs_enable.an", {6'h0, an}, 8'h02);
    idle(10, "post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
